// File: rtl/ones_checksum_pkg.sv
// Shared definitions for the nibble-wide one's-complement checksum checker:
// FSM state encoding and the one's-complement "negative zero" target value.
package ones_checksum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // A frame whose nibbles (checksum included) sum to all-ones is intact.
    localparam logic [3:0] ONES_NEG_ZERO = 4'hF;

endpackage

// File: rtl/ones_checksum_check_add4.sv
// 4-bit one's-complement adder: carry out of bit 3 wraps back into bit 0.
module ones_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);

    logic [4:0] w_raw;

    // Worst case 4'hF + 4'hF = 5'h1E, so the wrapped add can never carry again.
    always_comb begin
        w_raw = {1'b0, a} + {1'b0, b};
        y     = w_raw[3:0] + {3'b000, w_raw[4]};
    end

endmodule

// File: rtl/ones_checksum_check.sv
// Frame checker: accumulates nibbles with end-around carry and posts a one-cycle
// done pulse with ok (sum is negative zero) or err (frame longer than MAX_WORDS).
module ones_checksum_check
    import ones_checksum_pkg::*;
#(
    parameter int MAX_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       valid,
    input  logic [3:0] data,
    input  logic       last,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic       err,
    output logic [3:0] sum,
    output logic [7:0] count
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

    state_t     r_state;
    logic       r_busy;
    logic       r_done;
    logic       r_ok;
    logic       r_err;
    logic [3:0] r_sum;
    logic [7:0] r_count;

    logic [3:0] w_add;
    logic [3:0] w_first_sum;
    logic [7:0] w_first_cnt;
    logic       w_first_end;
    logic       w_full;

    ones_add4 u_add (
        .a (r_sum),
        .b (data),
        .y (w_add)
    );

    // Values loaded by a start strobe; a start with valid takes data as nibble one.
    always_comb begin
        w_first_sum = 4'h0;
        w_first_cnt = 8'h00;
        w_first_end = 1'b0;
        if (valid) begin
            w_first_sum = data;
            w_first_cnt = 8'h01;
            w_first_end = last;
        end else begin
            w_first_sum = 4'h0;
            w_first_cnt = 8'h00;
            w_first_end = 1'b0;
        end
        w_full = (r_count == MAX_CNT);
    end

    // Frame sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_sum   <= 4'h0;
            r_count <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ok    <= 1'b0;
                        r_err   <= 1'b0;
                        r_sum   <= w_first_sum;
                        r_count <= w_first_cnt;
                        if (w_first_end) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ok    <= (w_first_sum == ONES_NEG_ZERO);
                        end else begin
                            r_state <= ST_ACCUM;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    r_done <= 1'b0;
                    // A start here silently abandons the running frame.
                    if (start) begin
                        r_ok    <= 1'b0;
                        r_err   <= 1'b0;
                        r_sum   <= w_first_sum;
                        r_count <= w_first_cnt;
                        if (w_first_end) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ok    <= (w_first_sum == ONES_NEG_ZERO);
                        end else begin
                            r_state <= ST_ACCUM;
                            r_busy  <= 1'b1;
                        end
                    end else if (valid) begin
                        if (w_full) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ok    <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_sum   <= w_add;
                            r_count <= r_count + 8'h01;
                            if (last) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_ok    <= (w_add == ONES_NEG_ZERO);
                            end else begin
                                r_state <= ST_ACCUM;
                                r_busy  <= 1'b1;
                            end
                        end
                    end else begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign ok    = r_ok;
    assign err   = r_err;
    assign sum   = r_sum;
    assign count = r_count;

endmodule

// File: tb/tb_ones_checksum_check.sv
// Directed-vector bench: frame results are queued as stimulus is issued and a
// negedge monitor compares them against every done pulse the DUT produces.
module tb_ones_checksum_check;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = 4'h0;
    logic       last = 1'b0;
    logic       busy;
    logic       done;
    logic       ok;
    logic       err;
    logic [3:0] sum;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int seen     = 0;

    // {ok, err, sum, count}
    logic [13:0] exp_q[$];

    ones_checksum_check #(.MAX_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .valid (valid),
        .data  (data),
        .last  (last),
        .busy  (busy),
        .done  (done),
        .ok    (ok),
        .err   (err),
        .sum   (sum),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [3:0] d, input logic l);
        start = s;
        valid = v;
        data  = d;
        last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic e_ok, input logic e_err, input logic [3:0] e_sum,
                                input logic [7:0] e_cnt);
        exp_q.push_back({e_ok, e_err, e_sum, e_cnt});
        pushed++;
    endtask

    // Monitor: every done pulse must match the oldest queued frame result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (sum=%0h count=%0d)",
                         sum, count);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                check("frame_ok",    {15'h0, ok},    {15'h0, e[13]});
                check("frame_err",   {15'h0, err},   {15'h0, e[12]});
                check("frame_sum",   {12'h0, sum},   {12'h0, e[11:8]});
                check("frame_count", {8'h0, count},  {8'h0, e[7:0]});
                check("frame_busy",  {15'h0, busy},  16'h0000);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 4'h7, 1'b0);
        check("reset_state", {3'b0, busy, done, ok, err, sum, count}, 16'h0000);
        rst_n = 1'b1;

        // Idle noise: valid without start is ignored.
        drive(1'b0, 1'b1, 4'hA, 1'b0);
        drive(1'b0, 1'b1, 4'h5, 1'b1);
        check("idle_noise_count", {8'h0, count}, 16'h0000);
        check("idle_noise_busy",  {15'h0, busy}, 16'h0000);

        // Good frame 3,5,7,0.
        drive(1'b1, 1'b1, 4'h3, 1'b0);
        check("good_busy", {15'h0, busy}, 16'h0001);
        check("good_first_sum", {12'h0, sum}, 16'h0003);
        drive(1'b0, 1'b1, 4'h5, 1'b0);
        drive(1'b0, 1'b1, 4'h7, 1'b0);
        expect_frame(1'b1, 1'b0, 4'hF, 8'd4);
        drive(1'b0, 1'b1, 4'h0, 1'b1);
        check("good_done_latency", {15'h0, done}, 16'h0001);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        check("good_done_width", {15'h0, done}, 16'h0000);
        check("good_ok_hold", {15'h0, ok}, 16'h0001);

        // End-around carry: 9,8,D.
        drive(1'b1, 1'b1, 4'h9, 1'b0);
        drive(1'b0, 1'b1, 4'h8, 1'b0);
        check("carry_mid_sum", {12'h0, sum}, 16'h0002);
        check("carry_ok_cleared", {15'h0, ok}, 16'h0000);
        expect_frame(1'b1, 1'b0, 4'hF, 8'd3);
        drive(1'b0, 1'b1, 4'hD, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // Corrupt checksum 9,8,C, with a start during DONE that must be ignored.
        drive(1'b1, 1'b1, 4'h9, 1'b0);
        drive(1'b0, 1'b1, 4'h8, 1'b0);
        expect_frame(1'b0, 1'b0, 4'hE, 8'd3);
        drive(1'b0, 1'b1, 4'hC, 1'b1);
        drive(1'b1, 1'b1, 4'h7, 1'b0);
        check("done_start_ignored_busy", {15'h0, busy}, 16'h0000);
        check("done_start_ignored_sum", {12'h0, sum}, 16'h000E);
        check("done_start_ignored_cnt", {8'h0, count}, 16'h0003);

        // Gaps: 3, gap, 5, C -> 3+5=8, 8+C=0x14 -> 5.
        drive(1'b1, 1'b1, 4'h3, 1'b0);
        drive(1'b0, 1'b0, 4'h9, 1'b0);
        check("gap_sum_hold", {12'h0, sum}, 16'h0003);
        check("gap_count_hold", {8'h0, count}, 16'h0001);
        drive(1'b0, 1'b1, 4'h5, 1'b0);
        expect_frame(1'b0, 1'b0, 4'h5, 8'd3);
        drive(1'b0, 1'b1, 4'hC, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // Overflow with MAX_WORDS=4: five nibbles of 1, no last.
        drive(1'b1, 1'b1, 4'h1, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 1'b0);
        check("ovf_full_no_done", {15'h0, done}, 16'h0000);
        check("ovf_full_count", {8'h0, count}, 16'h0004);
        expect_frame(1'b0, 1'b1, 4'h4, 8'd4);
        drive(1'b0, 1'b1, 4'h1, 1'b0);
        check("ovf_done", {15'h0, done}, 16'h0001);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        check("ovf_err_hold", {15'h0, err}, 16'h0001);

        // Restart mid-frame: no done for the abandoned frame.
        drive(1'b1, 1'b1, 4'h1, 1'b0);
        check("restart_err_cleared", {15'h0, err}, 16'h0000);
        drive(1'b0, 1'b1, 4'h2, 1'b0);
        drive(1'b1, 1'b1, 4'h6, 1'b0);
        check("restart_count", {8'h0, count}, 16'h0001);
        check("restart_sum", {12'h0, sum}, 16'h0006);
        check("restart_no_done", {15'h0, done}, 16'h0000);
        expect_frame(1'b1, 1'b0, 4'hF, 8'd2);
        drive(1'b0, 1'b1, 4'h9, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // Reset mid-frame, then a one-nibble frame from cold IDLE.
        drive(1'b1, 1'b1, 4'h5, 1'b0);
        drive(1'b0, 1'b1, 4'h3, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 4'h4, 1'b1);
        check("reset_mid_frame", {3'b0, busy, done, ok, err, sum, count}, 16'h0000);
        rst_n = 1'b1;
        expect_frame(1'b1, 1'b0, 4'hF, 8'd1);
        drive(1'b1, 1'b1, 4'hF, 1'b1);
        check("single_nibble_done", {15'h0, done}, 16'h0001);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        check("pending_results", 16'(exp_q.size()), 16'h0000);
        check("done_pulse_count", 16'(seen), 16'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ones_checksum_check.md
ONES_CHECKSUM_CHECK -- requirements
Module: ones_checksum_check

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16: maximum nibbles per frame, including the checksum nibble; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1: frame-begin strobe; clears the accumulator.
REQ-005 SHALL have port valid, input, 1: data holds a frame nibble this cycle.
REQ-006 SHALL have port data, input, 4: frame nibble, checksum nibble last.
REQ-007 SHALL have port last, input, 1: qualifies with valid; marks the final nibble of the frame.
REQ-008 SHALL have port busy, output, 1: high while in ACCUM.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a frame result is posted.
REQ-010 SHALL have port ok, output, 1: last frame summed to 4'hF (one's-complement negative zero).
REQ-011 SHALL have port err, output, 1: last frame exceeded MAX_WORDS.
REQ-012 SHALL have port sum, output, 4: running / final one's-complement sum.
REQ-013 SHALL have port count, output, 8: nibbles accepted in the current/last frame.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; all outputs driven from registers.
REQ-015 SHALL add with end-around carry: 5-bit sum of sum and data, then bit 4 added back into bits 3:0 (for example, 4'hF + 4'hF gives 4'hF).
REQ-016 IDLE: valid without start SHALL be ignored; start SHALL clear sum and count and enter ACCUM.
REQ-017 A cycle with start and valid both high SHALL accept data as the first nibble (sum=data, count=1).
REQ-018 ACCUM: each valid cycle SHALL update sum and increment count by 1; cycles with valid low SHALL hold state.
REQ-019 valid and last in the same cycle SHALL accept the nibble and enter DONE next cycle; start, valid and last in one cycle form a one-nibble frame.
REQ-020 DONE SHALL last exactly one cycle: done=1, ok=(sum==4'hF), err=0, then return to IDLE.
REQ-021 Accepting a nibble with count already equal to MAX_WORDS SHALL abort the frame: enter DONE, done=1, err=1, ok=0, sum frozen, count saturated at MAX_WORDS.
REQ-022 start while in ACCUM SHALL abort the current frame without asserting done and restart per REQ-016/REQ-017; start while in DONE SHALL be ignored.
REQ-023 ok, err, sum and count SHALL hold after DONE until the next start; ok and err SHALL clear on start.
REQ-024 Latency: done SHALL rise in the cycle after the last nibble is accepted; throughput SHALL be one nibble per cycle.

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE with busy=0, done=0, ok=0, err=0, sum=4'h0, count=8'h00, overriding all other inputs, including mid-frame.
REQ-026 The first start accepted after reset release SHALL behave as from cold IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (2-bit enum IDLE/ACCUM/DONE) and the constant ONES_NEG_ZERO = 4'hF.
REQ-028 The end-around adder SHALL be a single combinational sub-module, ones_add4 (inputs a[3:0], b[3:0]; output y[3:0]); all sequencing SHALL live in ones_checksum_check.

Verification
REQ-029 Good frame: start+valid 3, then 5, 7, 0 (last) -> done pulse one cycle later; sum=F, ok=1, err=0, count=4.
REQ-030 End-around carry: 9, 8, D (last) -> intermediate sum=2 after the second nibble; final sum=F, ok=1.
REQ-031 Corrupt checksum: 9, 8, C (last) -> sum=E, ok=0, err=0, done one cycle.
REQ-032 Overflow with MAX_WORDS=4: five valid nibbles, no last -> done on the fifth acceptance +1 cycle; err=1, ok=0, count=4.
REQ-033 Restart and reset: start mid-frame after 2 nibbles -> no done, count restarts at 1; rst_n=0 mid-frame -> all outputs zero next cycle, busy=0.
REQ-034 Gaps and idle noise: valid low cycles inside a frame do not change sum; valid in IDLE without start leaves count=0.
